// File: rtl/idma_legalizer_mc_pkg.sv
// Shared types and helpers for the multi-channel iDMA AXI legalizer.
package idma_legalizer_mc_pkg;

  typedef enum logic {
    SlotIdle,
    SlotActive
  } slot_state_e;

  // Largest burst in bytes: capped by the beat limit and by the 4 KiB page.
  function automatic int unsigned burst_bytes(int unsigned max_beats, int unsigned strb_width);
    return (max_beats * strb_width < 4096) ? max_beats * strb_width : 4096;
  endfunction

endpackage

// File: rtl/idma_legalizer_mc_boundary.sv
// Distance in bytes from an address to the next BurstBytes-aligned boundary.
module idma_legalizer_mc_boundary #(
  parameter int unsigned BurstBytes = 128
) (
  input  logic [$clog2(BurstBytes)-1:0] addr_low,
  output logic [$clog2(BurstBytes):0]   bytes_to_pb
);

  localparam int unsigned BbLog = $clog2(BurstBytes);
  localparam logic [BbLog:0] BbVal = BurstBytes[BbLog:0];

  assign bytes_to_pb = BbVal - {1'b0, addr_low};

endmodule

// File: rtl/idma_legalizer_mc_axi.sv
// Splits one 1D transfer per channel into page- and length-legal AXI bursts,
// interleaving active channels round-robin onto a coupled AR/AW request.
module idma_legalizer_mc_axi
  import idma_legalizer_mc_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned LenWidth    = 32,
  parameter int unsigned MaxBeats    = 256
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [NumChannels*AddrWidth-1:0]                   req_src_addr_i,
  input  logic [NumChannels*AddrWidth-1:0]                   req_dst_addr_i,
  input  logic [NumChannels*LenWidth-1:0]                    req_length_i,
  input  logic [NumChannels-1:0]                             req_valid_i,
  output logic [NumChannels-1:0]                             req_ready_o,
  input  logic [NumChannels-1:0]                             kill_i,
  output logic [AddrWidth-1:0]                               r_addr_o,
  output logic [7:0]                                         r_len_o,
  output logic [$clog2(DataWidth/8)-1:0]                     r_offset_o,
  output logic                                               r_valid_o,
  input  logic                                               r_ready_i,
  output logic [AddrWidth-1:0]                               w_addr_o,
  output logic [7:0]                                         w_len_o,
  output logic [$clog2(DataWidth/8)-1:0]                     w_offset_o,
  output logic                                               w_last_o,
  output logic                                               w_valid_o,
  input  logic                                               w_ready_i,
  output logic [((NumChannels > 1) ? $clog2(NumChannels) : 1)-1:0] chan_o,
  output logic [NumChannels-1:0]                             done_o,
  output logic [NumChannels-1:0]                             busy_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);
  localparam int unsigned BurstBytes  = burst_bytes(MaxBeats, StrbWidth);
  localparam int unsigned PbWidth     = $clog2(BurstBytes) + 1;
  localparam int unsigned ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  remaining;
    slot_state_e          state;
  } slot_t;

  function automatic logic [ChanWidth-1:0] rr_idx(int unsigned base, int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NumChannels) s = s - NumChannels;
    return ChanWidth'(s);
  endfunction

  slot_t                  slots [NumChannels];
  logic [NumChannels-1:0] active;
  logic [NumChannels-1:0] done_q;
  logic                   locked;
  logic [ChanWidth-1:0]   lock_idx;
  logic [ChanWidth-1:0]   ptr;
  logic [ChanWidth-1:0]   grant;
  logic                   found;
  logic                   fire;
  logic                   last;
  logic [PbWidth-1:0]     pb_src;
  logic [PbWidth-1:0]     pb_dst;
  logic [LenWidth-1:0]    chunk;
  logic [LenWidth-1:0]    r_span;
  logic [LenWidth-1:0]    w_span;

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      active[c] = (slots[c].state == SlotActive);
    end
  end

  // A stalled grant stays put; a kill on it drops valid instead of re-arbitrating.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (locked) begin
      grant = lock_idx;
      found = active[lock_idx] & ~kill_i[lock_idx];
    end else begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (!found && active[rr_idx(32'(ptr), i)] && !kill_i[rr_idx(32'(ptr), i)]) begin
          found = 1'b1;
          grant = rr_idx(32'(ptr), i);
        end
      end
    end
  end

  idma_legalizer_mc_boundary #(.BurstBytes(BurstBytes)) i_pb_src (
    .addr_low    (slots[grant].src[PbWidth-2:0]),
    .bytes_to_pb (pb_src)
  );

  idma_legalizer_mc_boundary #(.BurstBytes(BurstBytes)) i_pb_dst (
    .addr_low    (slots[grant].dst[PbWidth-2:0]),
    .bytes_to_pb (pb_dst)
  );

  always_comb begin
    chunk = slots[grant].remaining;
    if (LenWidth'(pb_src) < chunk) chunk = LenWidth'(pb_src);
    if (LenWidth'(pb_dst) < chunk) chunk = LenWidth'(pb_dst);
    r_span = chunk + LenWidth'(slots[grant].src[OffsetWidth-1:0]) - LenWidth'(1);
    w_span = chunk + LenWidth'(slots[grant].dst[OffsetWidth-1:0]) - LenWidth'(1);
    last   = (chunk == slots[grant].remaining);
    fire   = found & r_ready_i & w_ready_i;
  end

  always_comb begin
    r_addr_o   = '0;
    r_len_o    = '0;
    r_offset_o = '0;
    w_addr_o   = '0;
    w_len_o    = '0;
    w_offset_o = '0;
    w_last_o   = 1'b0;
    chan_o     = '0;
    if (found) begin
      r_addr_o   = {slots[grant].src[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
      r_len_o    = 8'(r_span >> OffsetWidth);
      r_offset_o = slots[grant].src[OffsetWidth-1:0];
      w_addr_o   = {slots[grant].dst[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
      w_len_o    = 8'(w_span >> OffsetWidth);
      w_offset_o = slots[grant].dst[OffsetWidth-1:0];
      w_last_o   = last;
      chan_o     = grant;
    end
  end

  assign r_valid_o   = found;
  assign w_valid_o   = found;
  assign req_ready_o = ~active & ~kill_i;
  assign busy_o      = active;
  assign done_o      = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        slots[c] <= '{src: '0, dst: '0, remaining: '0, state: SlotIdle};
      end
      done_q   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      ptr      <= '0;
    end else begin
      done_q <= '0;
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if (kill_i[c]) begin
          slots[c].state <= SlotIdle;
        end else if (fire && grant == ChanWidth'(c)) begin
          slots[c].src       <= slots[c].src + AddrWidth'(chunk);
          slots[c].dst       <= slots[c].dst + AddrWidth'(chunk);
          slots[c].remaining <= slots[c].remaining - chunk;
          if (last) begin
            slots[c].state <= SlotIdle;
            done_q[c]      <= 1'b1;
          end
        end else if (req_valid_i[c] && !active[c]) begin
          slots[c].src       <= req_src_addr_i[c*AddrWidth +: AddrWidth];
          slots[c].dst       <= req_dst_addr_i[c*AddrWidth +: AddrWidth];
          slots[c].remaining <= req_length_i[c*LenWidth +: LenWidth];
          if (req_length_i[c*LenWidth +: LenWidth] != '0) begin
            slots[c].state <= SlotActive;
          end else begin
            done_q[c] <= 1'b1;
          end
        end
      end
      if (fire || (locked && kill_i[lock_idx])) begin
        locked <= 1'b0;
      end else if (found && !(r_ready_i && w_ready_i)) begin
        locked   <= 1'b1;
        lock_idx <= grant;
      end
      if (fire) ptr <= rr_idx(32'(grant), 1);
    end
  end

endmodule

// File: tb/tb_idma_legalizer_mc_axi.sv
// Bench for idma_legalizer_mc_axi: directed scenarios plus random traffic
// compared against a burst-list model built from the splitting rules.
module tb_idma_legalizer_mc_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] src_v, dst_v, len_v;
  logic [1:0]  req_valid, req_ready, kill, done, busy;
  logic [31:0] r_addr, w_addr;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_off, w_off;
  logic        r_valid, w_valid, w_last, r_ready, w_ready;
  logic        chan;

  idma_legalizer_mc_axi #(
    .NumChannels(2), .DataWidth(64), .AddrWidth(32), .LenWidth(32), .MaxBeats(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_src_addr_i(src_v), .req_dst_addr_i(dst_v), .req_length_i(len_v),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .kill_i(kill),
    .r_addr_o(r_addr), .r_len_o(r_len), .r_offset_o(r_off),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .w_addr_o(w_addr), .w_len_o(w_len), .w_offset_o(w_off), .w_last_o(w_last),
    .w_valid_o(w_valid), .w_ready_i(w_ready),
    .chan_o(chan), .done_o(done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    logic [31:0] raddr;
    logic [31:0] waddr;
    int          rlen, wlen, roff, woff;
    bit          last;
  } burst_t;

  burst_t      exp_q[$];
  int          ptr_m, held;
  logic [1:0]  exp_done;
  logic [81:0] snap;
  int          errors = 0;
  int          checks = 0;

  task automatic check(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(int c);
    foreach (exp_q[i]) if (exp_q[i].chan == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_idx(int c);
    foreach (exp_q[i]) if (exp_q[i].chan == c) return i;
    return -1;
  endfunction

  task automatic remove_chan(int c);
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].chan == c) exp_q.delete(i);
  endtask

  // Splits a transfer at 128-byte boundaries of both addresses.
  task automatic push_transfer(int c, logic [31:0] s, logic [31:0] d, int unsigned len);
    int unsigned rem;
    rem = len;
    while (rem > 0) begin
      int unsigned ps, pd, ch;
      burst_t b;
      ps = 128 - (s % 128);
      pd = 128 - (d % 128);
      ch = rem;
      if (ps < ch) ch = ps;
      if (pd < ch) ch = pd;
      b.chan  = c;
      b.raddr = s - (s % 8);
      b.roff  = int'(s % 8);
      b.rlen  = int'((s % 8 + ch + 7) / 8) - 1;
      b.waddr = d - (d % 8);
      b.woff  = int'(d % 8);
      b.wlen  = int'((d % 8 + ch + 7) / 8) - 1;
      b.last  = (ch == rem);
      exp_q.push_back(b);
      s   = s + ch;
      d   = d + ch;
      rem = rem - ch;
    end
  endtask

  task automatic request(int c, logic [31:0] s, logic [31:0] d, logic [31:0] len);
    src_v[c*32 +: 32] = s;
    dst_v[c*32 +: 32] = d;
    len_v[c*32 +: 32] = len;
    req_valid[c]      = 1'b1;
  endtask

  task automatic cycle();
    int         exp_chan, idx;
    bit         exp_valid, fire;
    logic [1:0] acc;
    logic [81:0] cur;
    #1;
    exp_chan = -1;
    if (held >= 0) begin
      if (!kill[held]) exp_chan = held;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int c;
        c = (ptr_m + i) % 2;
        if (exp_chan < 0 && pending(c) && !kill[c]) exp_chan = c;
      end
    end
    exp_valid = (exp_chan >= 0);
    check("r_valid", 96'(r_valid), 96'(exp_valid));
    check("w_valid", 96'(w_valid), 96'(exp_valid));
    for (int c = 0; c < 2; c++) begin
      acc[c] = req_valid[c] && !pending(c) && !kill[c];
      check("req_ready", 96'(req_ready[c]), 96'(!pending(c) && !kill[c]));
    end
    cur = {r_addr, r_len, w_addr, w_len, chan, w_last};
    if (exp_valid && r_valid) begin
      idx = first_idx(exp_chan);
      check("chan", 96'(chan), 96'(exp_chan));
      check("r_addr", 96'(r_addr), 96'(exp_q[idx].raddr));
      check("r_len", 96'(r_len), 96'(exp_q[idx].rlen));
      check("r_offset", 96'(r_off), 96'(exp_q[idx].roff));
      check("w_addr", 96'(w_addr), 96'(exp_q[idx].waddr));
      check("w_len", 96'(w_len), 96'(exp_q[idx].wlen));
      check("w_offset", 96'(w_off), 96'(exp_q[idx].woff));
      check("w_last", 96'(w_last), 96'(exp_q[idx].last));
      if (held >= 0) check("stall_stable", 96'(cur), 96'(snap));
    end
    fire = exp_valid && r_ready && w_ready;
    @(posedge clk);
    exp_done = '0;
    for (int c = 0; c < 2; c++) begin
      if (kill[c]) begin
        remove_chan(c);
        if (held == c) held = -1;
      end
    end
    if (fire) begin
      idx = first_idx(exp_chan);
      if (exp_q[idx].last) exp_done[exp_chan] = 1'b1;
      exp_q.delete(idx);
      ptr_m = (exp_chan + 1) % 2;
      held  = -1;
    end else if (exp_valid) begin
      held = exp_chan;
      snap = cur;
    end
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        if (len_v[c*32 +: 32] == 0) exp_done[c] = 1'b1;
        else push_transfer(c, src_v[c*32 +: 32], dst_v[c*32 +: 32], len_v[c*32 +: 32]);
      end
    end
    #1;
    req_valid = req_valid & ~acc;
    check("done", 96'(done), 96'(exp_done));
    check("busy", 96'(busy), 96'({pending(1), pending(0)}));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    kill      = '0;
    @(posedge clk);
    #1;
    check("rst_r_valid", 96'(r_valid), 96'(0));
    check("rst_w_valid", 96'(w_valid), 96'(0));
    check("rst_addr", 96'({r_addr, w_addr}), 96'(0));
    check("rst_len", 96'({r_len, w_len}), 96'(0));
    check("rst_chan", 96'(chan), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    rst = 1'b0;
    exp_q.delete();
    ptr_m    = 0;
    held     = -1;
    exp_done = '0;
  endtask

  task automatic drain();
    int n;
    r_ready = 1'b1;
    w_ready = 1'b1;
    kill    = '0;
    n = 0;
    while ((exp_q.size() > 0 || req_valid != 0) && n < 3000) begin
      cycle();
      n++;
    end
    check("drain_empty", 96'(exp_q.size()), 96'(0));
    cycle();
  endtask

  initial begin
    src_v = '0; dst_v = '0; len_v = '0;
    r_ready = 1'b1; w_ready = 1'b1;
    ptr_m = 0; held = -1; exp_done = '0; snap = '0;
    do_reset();
    do_reset();

    // Single channel crossing both pages at different offsets.
    request(0, 32'h1004, 32'h2000, 300);
    drain();

    // Two channels interleaving from pointer 0.
    do_reset();
    request(0, 32'h0, 32'h8000, 256);
    request(1, 32'h0, 32'h8000, 256);
    drain();

    // Write backpressure mid-transfer.
    request(0, 32'h40, 32'h3000, 512);
    cycle();
    cycle();
    w_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    drain();

    // Zero-length request.
    request(1, 32'h100, 32'h200, 0);
    cycle();
    cycle();
    cycle();

    // Kill on a stalled grant.
    request(0, 32'h5000, 32'h6000, 400);
    request(1, 32'h7000, 32'h9000, 400);
    w_ready = 1'b0;
    cycle();
    cycle();
    cycle();
    if (held >= 0) kill[held] = 1'b1;
    cycle();
    kill    = '0;
    w_ready = 1'b1;
    drain();

    // Reset in the middle of a transfer, then a fresh request.
    request(0, 32'h123, 32'h456, 1000);
    for (int i = 0; i < 4; i++) cycle();
    do_reset();
    request(0, 32'h88, 32'hFFC, 200);
    drain();

    // Random traffic with random readies and occasional kills.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pending(c) && !req_valid[c] && $urandom_range(0, 3) == 0)
          request(c, $urandom, $urandom,
                  ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 700)));
        kill[c] = ($urandom_range(0, 39) == 0);
      end
      r_ready = ($urandom_range(0, 3) != 0);
      w_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
